// File: rtl/tcu_sched_pkg.sv
`default_nettype none
// =============================================================================
// tcu_sched_pkg: shared types and constants for the I2C transaction scheduler.
// Revision: 1.0
// =============================================================================
package tcu_sched_pkg;

  // Width of the command payload; the scheduler's CU_WIDTH must match it.
  localparam int   CMD_W          = 16;
  localparam int   BACKOFF_CYCLES = 16;
  localparam logic RW_READ        = 1'b1;
  localparam logic RW_WRITE       = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } state_e;

  typedef struct packed {
    logic             rw;
    logic [7:0]       reg_addr;
    logic [CMD_W-1:0] wdata;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/i2c_txn_scheduler_poll_timer.sv
`default_nettype none
// =============================================================================
// poll_timer: free-running poll period counter with a single pending-poll flag.
// Revision: 1.0
// =============================================================================
module poll_timer #(
  parameter int POLL_PERIOD = 150000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic on_off_i,
  input  logic take_i,
  output logic poll_pend_o
);

  localparam int            CW   = $clog2(POLL_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(POLL_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          pend_q;

  // A wrap in the same cycle as a take re-arms the flag, so no tick is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else if (!on_off_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      pend_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      if (take_i) pend_q <= 1'b0;
    end
  end

  assign poll_pend_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/i2c_txn_scheduler.sv
`default_nettype none
// =============================================================================
// i2c_txn_scheduler: periodic sensor polls and host writes through one I2C
// master, with NACK/timeout retry. Optional averaging: SAMPLE_AVG_EN.
// Revision: 1.0
// =============================================================================
module i2c_txn_scheduler #(
  parameter int         CU_WIDTH         = 16,
  parameter logic [6:0] SENSOR_ADDRESS   = 7'b1111111,
  parameter logic [7:0] TARGET_READ_ADDR = 8'hFF,
  parameter int         POLL_PERIOD      = 150000,
  parameter int         MAX_RETRY        = 3,
  parameter int         TIMEOUT_CYCLES   = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                on_off,
  input  logic                cfg_req,
  input  logic [7:0]          cfg_reg_addr,
  input  logic [CU_WIDTH-1:0] cfg_wdata,
  output logic                cfg_ack,
  output logic                cfg_err,
  output logic                m_start,
  output logic                m_rw,
  output logic [6:0]          m_dev_addr,
  output logic [7:0]          m_reg_addr,
  output logic [CU_WIDTH-1:0] m_wdata,
  input  logic                m_busy,
  input  logic                m_done,
  input  logic                m_nack,
  input  logic [CU_WIDTH-1:0] m_rdata,
  output logic [CU_WIDTH-1:0] temp_data,
  output logic                data_valid,
  output logic                sensor_fault
);
  import tcu_sched_pkg::*;

  localparam int              RC_W      = $clog2(MAX_RETRY + 2);
  localparam logic [RC_W-1:0] RETRY_LIM = RC_W'(MAX_RETRY);
  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam int              BO_W      = $clog2(BACKOFF_CYCLES);
  localparam logic [BO_W-1:0] BO_LAST   = BO_W'(BACKOFF_CYCLES - 1);

  state_e              state_q;
  cmd_t                cmd_q;
  logic [6:0]          dev_q;
  logic [RC_W-1:0]     retry_q;
  logic [TO_W-1:0]     to_q;
  logic [BO_W-1:0]     bo_q;
  logic                start_q, ack_q, err_q, fault_q;
  logic [CU_WIDTH-1:0] temp_q;

  logic w_poll_pend, w_poll_take, w_cfg_take, w_rd_ok;

  // Ignore cfg_req while the completion pulse is out: the host needs a cycle to drop it.
  assign w_cfg_take  = cfg_req && !ack_q && !err_q;
  assign w_poll_take = (state_q == IDLE) && !w_cfg_take && w_poll_pend;
  assign w_rd_ok     = (state_q == WAIT) && m_done && !m_nack && (cmd_q.rw == RW_READ);

  poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_poll_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .on_off_i   (on_off),
    .take_i     (w_poll_take),
    .poll_pend_o(w_poll_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      dev_q   <= '0;
      retry_q <= '0;
      to_q    <= '0;
      bo_q    <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (w_cfg_take) begin
            cmd_q   <= '{rw: RW_WRITE, reg_addr: cfg_reg_addr, wdata: cfg_wdata};
            dev_q   <= SENSOR_ADDRESS;
            retry_q <= '0;
            state_q <= ISSUE;
          end else if (w_poll_pend) begin
            cmd_q   <= '{rw: RW_READ, reg_addr: TARGET_READ_ADDR, wdata: '0};
            dev_q   <= SENSOR_ADDRESS;
            retry_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_busy) begin
            start_q <= 1'b1;
            to_q    <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          to_q <= to_q + TO_W'(1);
          if (m_done && !m_nack) begin
            if (cmd_q.rw == RW_READ) fault_q <= 1'b0;
            else                     ack_q   <= 1'b1;
            state_q <= IDLE;
          end else if (m_done || (to_q == TO_LAST)) begin
            retry_q <= retry_q + RC_W'(1);
            bo_q    <= '0;
            state_q <= BACKOFF;
          end
        end
        BACKOFF: begin
          bo_q <= bo_q + BO_W'(1);
          if (bo_q == BO_LAST) begin
            if (retry_q <= RETRY_LIM) begin
              state_q <= ISSUE;
            end else begin
              if (cmd_q.rw == RW_READ) fault_q <= 1'b1;
              else                     err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef SAMPLE_AVG_EN
  logic                dv_q, have_q, w_rd_fail;
  logic [CU_WIDTH:0]   w_sum;

  assign w_sum     = {1'b0, temp_q} + {1'b0, m_rdata};
  assign w_rd_fail = (state_q == BACKOFF) && (bo_q == BO_LAST) &&
                     (retry_q > RETRY_LIM) && (cmd_q.rw == RW_READ);

  // temp_q only ever holds good samples, so it doubles as the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q <= '0;
      dv_q   <= 1'b0;
      have_q <= 1'b0;
    end else begin
      dv_q <= w_rd_ok;
      if (w_rd_ok) begin
        temp_q <= have_q ? w_sum[CU_WIDTH:1] : m_rdata;
        have_q <= 1'b1;
      end else if (w_rd_fail) begin
        have_q <= 1'b0;
      end
    end
  end

  assign temp_data  = temp_q;
  assign data_valid = dv_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       temp_q <= '0;
    else if (w_rd_ok) temp_q <= m_rdata;
  end

  assign temp_data  = w_rd_ok ? m_rdata : temp_q;
  assign data_valid = w_rd_ok;
`endif

  assign cfg_ack      = ack_q;
  assign cfg_err      = err_q;
  assign m_start      = start_q;
  assign m_rw         = cmd_q.rw;
  assign m_dev_addr   = dev_q;
  assign m_reg_addr   = cmd_q.reg_addr;
  assign m_wdata      = cmd_q.wdata;
  assign sensor_fault = fault_q;

endmodule
`default_nettype wire

// File: doc/i2c_txn_scheduler.md
Name: i2c_txn_scheduler

Overview:
- Sequences all traffic through the shared I2C master in the temperature control unit.
- Issues periodic temperature-register reads to the P3T1035/P3T2030 sensor and arbitrates them against host configuration writes.
- Retries NACKed or timed-out transactions and publishes validated samples to the control unit (CU).
- Sits between the CU/host logic and the I2C master command interface, inside TCU_wrapper.

Parameters:
CU_WIDTH, 16, width of sensor read/write data
SENSOR_ADDRESS, 7'b1111111, 7-bit I2C device address placed on every command
TARGET_READ_ADDR, 8'hFF, sensor register address polled for temperature
POLL_PERIOD, 150000, clk cycles between poll launches (1 ms at 150 MHz); must be >= 2
MAX_RETRY, 3, retries after the first attempt before declaring failure
TIMEOUT_CYCLES, 65535, max cycles from m_start to m_done before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
on_off  in  1  1 = polling enabled; 0 = polling stops after the current transaction
cfg_req  in  1  host write request; level, held until cfg_ack or cfg_err
cfg_reg_addr  in  8  register address for the host write
cfg_wdata  in  CU_WIDTH  write data
cfg_ack  out  1  1-cycle pulse: host write completed with ACK
cfg_err  out  1  1-cycle pulse: host write failed after all retries
m_start  out  1  1-cycle command pulse to the I2C master
m_rw  out  1  1 = read, 0 = write
m_dev_addr  out  7  device address
m_reg_addr  out  8  register address
m_wdata  out  CU_WIDTH  write payload
m_busy  in  1  master busy
m_done  in  1  1-cycle transaction-complete pulse
m_nack  in  1  valid with m_done: 1 = any byte NACKed
m_rdata  in  CU_WIDTH  read data, valid with m_done
temp_data  out  CU_WIDTH  last good sample, held between updates
data_valid  out  1  1-cycle pulse when temp_data updates
sensor_fault  out  1  sticky; set when a poll exhausts its retries, cleared by the next good poll

Behaviour:
- Reset: all outputs 0; m_* command fields 0; poll counter 0; state IDLE.
- Poll timer counts while on_off=1. At POLL_PERIOD-1 it sets poll_pend and wraps to 0. While on_off=0 the timer is held at 0 and poll_pend is cleared.
- States:
  - IDLE: if cfg_req, go to ISSUE with a write command; else if poll_pend, go to ISSUE with a read command. A host write beats a pending poll. Only one pending poll is kept; extra wraps are dropped.
  - ISSUE: wait for m_busy=0, then drive m_start=1 for exactly one cycle with the command fields stable. The fields stay stable until the transaction ends. Clear the timeout counter. Go to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - m_done and !m_nack: success. Read: temp_data <= m_rdata, data_valid pulses the same cycle, sensor_fault <= 0. Write: cfg_ack pulses. Go to IDLE.
    - m_done and m_nack, or counter reaches TIMEOUT_CYCLES: retry_cnt++ and go to BACKOFF.
    - If m_done and timeout coincide, m_done wins.
  - BACKOFF: wait 16 cycles. If retry_cnt <= MAX_RETRY, go to ISSUE with the same command. Otherwise fail: a poll sets sensor_fault; a write pulses cfg_err. Go to IDLE.
- retry_cnt is cleared on each new command taken from IDLE.
- A poll is latched in IDLE and clears poll_pend at that point, so a tick arriving mid-transaction re-pends.
- on_off dropping mid-poll does not abort; the poll result is still published.
- cfg_req dropping mid-transaction is ignored; completion is still pulsed.
- Latency: a successful poll gives data_valid on the cycle m_done arrives (0 added cycles). IDLE to m_start takes 2 cycles when the master is idle.
- Asynchronous reset at any time returns to IDLE. No m_start is issued in the reset cycle.

Optional Feature:
- SAMPLE_AVG_EN defined:
  - temp_data = (prev_good + m_rdata) >> 1, summed in CU_WIDTH+1 bits as unsigned, truncated to CU_WIDTH.
  - The first good sample after reset or after a fault passes through unaveraged.
  - Adds one register stage: data_valid arrives 1 cycle after m_done.
- Undefined: temp_data = raw m_rdata, same-cycle data_valid.

Decomposition:
- Package tcu_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, BACKOFF)
  - BACKOFF_CYCLES=16
  - RW_READ=1, RW_WRITE=0
  - cmd_t struct {rw, reg_addr, wdata}
- Sub-module poll_timer: counter, wrap, and poll_pend logic.

Test Plan:
- on_off=1, POLL_PERIOD=100, master ACKs with m_rdata=16'h1A2B -> exactly one m_start every 100 cycles with m_rw=1, m_reg_addr=8'hFF, m_dev_addr=7'h7F; temp_data=16'h1A2B with a data_valid pulse each poll.
- cfg_req raised with cfg_reg_addr=8'h01, cfg_wdata=16'h00A5 on the same cycle as poll_pend -> write issued first, cfg_ack pulses, then the read is issued.
- Master NACKs 2 times, then ACKs a poll -> 3 m_start pulses spaced by the 16-cycle backoff; data_valid=1 once; sensor_fault stays 0.
- Master NACKs 4 times (MAX_RETRY=3) -> sensor_fault=1 after the 4th; the next good poll clears it and updates temp_data.
- m_done withheld, TIMEOUT_CYCLES=50 -> retry launched 50+16 cycles after m_start. Separately, rst_n pulsed low mid-WAIT -> all outputs 0 immediately, no m_start in the reset cycle.
- SAMPLE_AVG_EN defined, samples 16'h0100 then 16'h0200 -> temp_data 16'h0100 then 16'h0180, each data_valid 1 cycle after m_done.
